// File: rtl/lsu_arbiter.sv
// Round-robin arbiter funnelling per-LSU read/write requests onto one data-memory channel.
// Optional perf counters (perf_grants, perf_stall_cycles) are built when LSU_ARB_PERF_EN is defined.
module lsu_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                req_read_valid,
  input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_read_address,
  output logic [NUM_REQUESTERS-1:0]                req_read_ready,
  output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_read_data,
  input  logic [NUM_REQUESTERS-1:0]                req_write_valid,
  input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_write_address,
  input  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_write_data,
  output logic [NUM_REQUESTERS-1:0]                req_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready,
  output logic                                     busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0]        grant_id
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [15:0]                              perf_grants,
  output logic [15:0]                              perf_stall_cycles
`endif
);

  // state      | meaning
  // IDLE       | no grant; scanning requesters from rr_ptr
  // READ_WAIT  | mem_read_valid held until mem_read_ready
  // WRITE_WAIT | mem_write_valid held until mem_write_ready
  // RELEASE    | ready held to granted LSU until its valid drops
  localparam int GW = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

  state_t                                 state_q, state_n;
  logic [GW-1:0]                          rr_ptr_q, rr_ptr_n, grant_n, rr_next;
  logic                                   mrv_n, mwv_n, busy_n;
  logic [ADDR_BITS-1:0]                   mra_n, mwa_n;
  logic [DATA_BITS-1:0]                   mwd_n;
  logic [NUM_REQUESTERS-1:0]              rrdy_n, wrdy_n;
  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] rdata_n;
  logic                                   found;
  logic [GW-1:0]                          pick, scan_idx;
  logic [GW:0]                            scan_sum;

  assign rr_next = (grant_id == GW'(NUM_REQUESTERS - 1)) ? '0 : grant_id + GW'(1);

  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    grant_n  = grant_id;
    mrv_n    = mem_read_valid;
    mra_n    = mem_read_address;
    mwv_n    = mem_write_valid;
    mwa_n    = mem_write_address;
    mwd_n    = mem_write_data;
    rrdy_n   = req_read_ready;
    wrdy_n   = req_write_ready;
    rdata_n  = req_read_data;
    found    = 1'b0;
    pick     = '0;
    scan_sum = '0;
    scan_idx = '0;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQUESTERS
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(NUM_REQUESTERS))
        scan_sum = scan_sum - (GW+1)'(NUM_REQUESTERS);
      scan_idx = scan_sum[GW-1:0];
      if (!found && (req_read_valid[scan_idx] || req_write_valid[scan_idx])) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          if (req_read_valid[pick]) begin
            mrv_n   = 1'b1;
            mra_n   = req_read_address[pick];
            state_n = READ_WAIT;
          end else begin
            mwv_n   = 1'b1;
            mwa_n   = req_write_address[pick];
            mwd_n   = req_write_data[pick];
            state_n = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mrv_n             = 1'b0;
          rdata_n[grant_id] = mem_read_data;
          rrdy_n[grant_id]  = 1'b1;
          state_n           = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mwv_n            = 1'b0;
          wrdy_n[grant_id] = 1'b1;
          state_n          = RELEASE;
        end
      end
      RELEASE: begin
        if ((req_read_ready[grant_id] && !req_read_valid[grant_id]) ||
            (req_write_ready[grant_id] && !req_write_valid[grant_id])) begin
          rrdy_n   = '0;
          wrdy_n   = '0;
          rr_ptr_n = rr_next;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      rr_ptr_q          <= '0;
      grant_id          <= '0;
      busy              <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      req_read_ready    <= '0;
      req_write_ready   <= '0;
      req_read_data     <= '0;
    end else begin
      state_q           <= state_n;
      rr_ptr_q          <= rr_ptr_n;
      grant_id          <= grant_n;
      busy              <= busy_n;
      mem_read_valid    <= mrv_n;
      mem_read_address  <= mra_n;
      mem_write_valid   <= mwv_n;
      mem_write_address <= mwa_n;
      mem_write_data    <= mwd_n;
      req_read_ready    <= rrdy_n;
      req_write_ready   <= wrdy_n;
      req_read_data     <= rdata_n;
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [NUM_REQUESTERS-1:0] others_waiting;

  assign others_waiting = (req_read_valid | req_write_valid) &
                          ~(NUM_REQUESTERS'(1) << grant_id);

  // Both counters saturate rather than wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state_q == IDLE && state_n != IDLE && perf_grants != 16'hFFFF)
        perf_grants <= perf_grants + 16'd1;
      if (state_q != IDLE && |others_waiting && perf_stall_cycles != 16'hFFFF)
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: scripted memory and LSU responders, per-scenario inline checks.
module tb_lsu_arbiter;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]         rv, wv, rrdy, wrdy;
  logic [N-1:0][AB-1:0] ra, wa;
  logic [N-1:0][DB-1:0] wd, rdata;
  logic                 mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready;
  logic [AB-1:0]        mem_read_address, mem_write_address;
  logic [DB-1:0]        mem_read_data, mem_write_data;
  logic                 busy;
  logic [1:0]           grant_id;
`ifdef LSU_ARB_PERF_EN
  logic [15:0]          perf_grants, perf_stall_cycles;
`endif

  lsu_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQUESTERS(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_read_valid    (rv),
    .req_read_address  (ra),
    .req_read_ready    (rrdy),
    .req_read_data     (rdata),
    .req_write_valid   (wv),
    .req_write_address (wa),
    .req_write_data    (wd),
    .req_write_ready   (wrdy),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready),
    .busy              (busy),
    .grant_id          (grant_id)
`ifdef LSU_ARB_PERF_EN
    ,
    .perf_grants       (perf_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];
  int  mem_lat  = 1;
  bit  mem_auto = 1'b1;
  int  viol     = 0;
  int  log_id[$];
  bit  log_wr[$];
  logic [7:0] log_data[$];

  // Memory: raise ready for one cycle mem_lat cycles after valid is seen
  initial begin : mem_resp
    int cnt;
    cnt = 0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !mem_auto || mem_read_ready || mem_write_ready) begin
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        cnt = 0;
      end else if (mem_read_valid || mem_write_valid) begin
        cnt++;
        if (cnt >= mem_lat) begin
          if (mem_read_valid) begin
            mem_read_data  = mem[mem_read_address];
            mem_read_ready = 1'b1;
          end else begin
            mem[mem_write_address] = mem_write_data;
            mem_write_ready = 1'b1;
          end
        end
      end
    end
  end

  // LSUs: drop valid once ready is seen; log completions; flag stray readies
  initial begin : lsu_resp
    forever begin
      @(posedge clk); #1;
      if ($countones(rrdy | wrdy) > 1) viol++;
      for (int i = 0; i < N; i++) begin
        if ((rrdy[i] || wrdy[i]) && int'(grant_id) != i) viol++;
        if (rrdy[i] && rv[i]) begin
          log_id.push_back(i); log_wr.push_back(1'b0); log_data.push_back(rdata[i]);
          rv[i] = 1'b0;
        end
        if (wrdy[i] && wv[i]) begin
          log_id.push_back(i); log_wr.push_back(1'b1); log_data.push_back(8'h00);
          wv[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_id.delete(); log_wr.delete(); log_data.delete();
    viol = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; rv = '0; wv = '0;
    tick(); tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_done(input int n, input string name);
    for (int c = 0; c < 300; c++) begin
      if (log_id.size() >= n && !busy) break;
      tick();
    end
    n_cmp++;
    if (log_id.size() != n || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s completions: got %0d busy=%b, want %0d busy=0", name, log_id.size(), busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_cmp++; if ({mem_read_valid, mem_write_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_mem_valid: got %b want 00", {mem_read_valid, mem_write_valid}); end
    n_cmp++; if ({mem_read_address, mem_write_address, mem_write_data} !== 24'h0) begin n_bad++; $display("FAIL reset_mem_addr_data: got %h want 0", {mem_read_address, mem_write_address, mem_write_data}); end
    n_cmp++; if ({rrdy, wrdy} !== 8'h00) begin n_bad++; $display("FAIL reset_ready: got %h want 00", {rrdy, wrdy}); end
    n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_single_read();
    int c;
    apply_reset();
    mem_lat = 3;
    mem[8'h35] = 8'hA7;
    ra[2] = 8'h35; rv[2] = 1'b1;
    tick();
    n_cmp++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h35) begin n_bad++; $display("FAIL single_issue: got v=%b a=%h want v=1 a=35", mem_read_valid, mem_read_address); end
    n_cmp++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL single_grant: got id=%0d busy=%b want id=2 busy=1", grant_id, busy); end
    c = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rrdy[2]) begin c = k; break; end
    end
    n_cmp++; if (c != 3) begin n_bad++; $display("FAIL single_latency: got %0d want 3", c); end
    n_cmp++; if (rdata[2] !== 8'hA7 || rrdy !== 4'b0100) begin n_bad++; $display("FAIL single_data: got d=%h rdy=%b want d=a7 rdy=0100", rdata[2], rrdy); end
    tick();
    n_cmp++; if (busy !== 1'b0 || rrdy !== 4'b0000 || rdata[2] !== 8'hA7) begin n_bad++; $display("FAIL single_release: got busy=%b rdy=%b d=%h want 0 0000 a7", busy, rrdy, rdata[2]); end
    clear_log();
    mem_lat = 1;
    ra[0] = 8'h01; ra[3] = 8'h02;
    rv[0] = 1'b1; rv[3] = 1'b1;
    tick();
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL single_rr_ptr: got %0d want 3", grant_id); end
    wait_done(2, "single_followup");
    n_cmp++; if (log_id.size() == 2 && (log_id[0] != 3 || log_id[1] != 0)) begin n_bad++; $display("FAIL single_rr_order: got %0d,%0d want 3,0", log_id[0], log_id[1]); end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    mem_lat = 1;
    for (int i = 0; i < N; i++) begin
      ra[i] = 8'(8'h40 + i);
      mem[8'(8'h40 + i)] = exp_d[i];
    end
    rv = 4'b1111;
    wait_done(4, "all4");
    for (int i = 0; i < N && i < log_id.size(); i++) begin
      n_cmp++;
      if (log_id[i] != i || log_data[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL all4_grant%0d: got id=%0d d=%h want id=%0d d=%h", i, log_id[i], log_data[i], i, exp_d[i]);
      end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL all4_stray_ready: got %0d want 0", viol); end
  endtask

  task automatic test_rw_mix();
    apply_reset();
    mem[8'h10] = 8'h00;
    wa[1] = 8'h10; wd[1] = 8'h5C; wv[1] = 1'b1;
    ra[3] = 8'h10; rv[3] = 1'b1;
    tick();
    n_cmp++; if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h10 || mem_write_data !== 8'h5C || mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL rw_write_issue: got wv=%b a=%h d=%h rv=%b want 1 10 5c 0", mem_write_valid, mem_write_address, mem_write_data, mem_read_valid); end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rw_grant: got %0d want 1", grant_id); end
    wait_done(2, "rw");
    n_cmp++; if (log_id.size() == 2 && (log_id[0] != 1 || log_wr[0] != 1'b1)) begin n_bad++; $display("FAIL rw_first: got id=%0d wr=%b want id=1 wr=1", log_id[0], log_wr[0]); end
    n_cmp++; if (log_id.size() == 2 && (log_id[1] != 3 || log_wr[1] != 1'b0 || log_data[1] !== 8'h5C)) begin n_bad++; $display("FAIL rw_second: got id=%0d wr=%b d=%h want id=3 wr=0 d=5c", log_id[1], log_wr[1], log_data[1]); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rw_stray_ready: got %0d want 0", viol); end
  endtask

  task automatic test_same_requester();
    int exp_id [4];
    bit exp_wr [4];
    exp_id = '{0, 2, 3, 2};
    exp_wr = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    ra[0] = 8'h22; mem[8'h22] = 8'h31;
    ra[2] = 8'h20; mem[8'h20] = 8'h42;
    wa[2] = 8'h21; wd[2] = 8'h99; mem[8'h21] = 8'h00;
    ra[3] = 8'h23; mem[8'h23] = 8'h53;
    rv[0] = 1'b1; rv[2] = 1'b1; wv[2] = 1'b1; rv[3] = 1'b1;
    wait_done(4, "same_req");
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      n_cmp++;
      if (log_id[i] != exp_id[i] || log_wr[i] != exp_wr[i]) begin
        n_bad++;
        $display("FAIL same_req_order%0d: got id=%0d wr=%b want id=%0d wr=%b", i, log_id[i], log_wr[i], exp_id[i], exp_wr[i]);
      end
    end
    n_cmp++; if (log_id.size() >= 2 && log_data[1] !== 8'h42) begin n_bad++; $display("FAIL same_req_rdata: got %h want 42", log_data[1]); end
    n_cmp++; if (mem[8'h21] !== 8'h99) begin n_bad++; $display("FAIL same_req_wdata: got %h want 99", mem[8'h21]); end
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0;
    ra[0] = 8'h50; rv[0] = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (mem_read_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got v=%b busy=%b want 1 1", mem_read_valid, busy); end
    reset = 1'b1; rv[0] = 1'b0;
    tick();
    n_cmp++; if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin n_bad++; $display("FAIL mid_reset_ctl: got v=%b a=%h busy=%b id=%0d want 0 00 0 0", mem_read_valid, mem_read_address, busy, grant_id); end
    n_cmp++; if ({rrdy, wrdy} !== 8'h00 || rdata !== '0) begin n_bad++; $display("FAIL mid_reset_lsu: got rdy=%h d=%h want 00 0", {rrdy, wrdy}, rdata); end
    reset = 1'b0;
    mem_auto = 1'b1;
    mem_lat = 1;
    clear_log();
    mem[8'h66] = 8'h7E;
    ra[1] = 8'h66; rv[1] = 1'b1;
    tick();
    n_cmp++; if (grant_id !== 2'd1 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h66) begin n_bad++; $display("FAIL mid_regrant: got id=%0d v=%b a=%h want 1 1 66", grant_id, mem_read_valid, mem_read_address); end
    wait_done(1, "mid_after");
    n_cmp++; if (log_id.size() == 1 && (log_id[0] != 1 || log_data[0] !== 8'h7E)) begin n_bad++; $display("FAIL mid_after_data: got id=%0d d=%h want 1 7e", log_id[0], log_data[0]); end
  endtask

`ifdef LSU_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    n_cmp++; if (perf_grants !== 16'd0 || perf_stall_cycles !== 16'd0) begin n_bad++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_grants, perf_stall_cycles); end
    mem_lat = 2;
    for (int i = 0; i < 3; i++) begin
      ra[i] = 8'(8'h70 + i);
      mem[8'(8'h70 + i)] = 8'(8'hE0 + i);
    end
    rv = 4'b0111;
    wait_done(3, "perf");
    n_cmp++; if (perf_grants !== 16'd3) begin n_bad++; $display("FAIL perf_grants: got %0d want 3", perf_grants); end
    n_cmp++; if (perf_stall_cycles !== 16'd6) begin n_bad++; $display("FAIL perf_stall: got %0d want 6", perf_stall_cycles); end
    mem_lat = 1;
  endtask
`endif

  initial begin : main
    reset = 1'b1;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_read();
    test_all_four();
    test_rw_mix();
    test_same_requester();
    test_reset_mid();
`ifdef LSU_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
